// File: rtl/rvc_asap_5pl_vga_timing_gen_if.sv
// Signal bundle between the VGA raster timing generator and its consumers.
// The master side receives the run request and drives the timing and event outputs.
interface rvc_asap_5pl_vga_timing_gen_if #(
  parameter int CNT_W = 10,
  parameter int FRM_W = 8
);
  logic             Enable;
  logic             vga_h_sync;
  logic             vga_v_sync;
  logic             inDisplayArea;
  logic [CNT_W-1:0] CounterX;
  logic [CNT_W-1:0] CounterY;
  logic             FrameStart;
  logic             LineStart;
  logic             VBlankStart;
  logic             Running;
  logic [FRM_W-1:0] FrameCount;

  modport master (
    input  Enable,
    output vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY,
           FrameStart, LineStart, VBlankStart, Running, FrameCount
  );

  modport slave (
    output Enable,
    input  vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY,
           FrameStart, LineStart, VBlankStart, Running, FrameCount
  );
endinterface

// File: rtl/rvc_asap_5pl_vga_timing_gen.sv
// Parametrised VGA raster timing generator with run/drain control, delayed sync/DE
// outputs (so pixel fetch sees the counters early) and frame/line/vblank event pulses.
module rvc_asap_5pl_vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int PIPE_DLY   = 1,
  parameter int CNT_W      = 10,
  parameter int FRM_W      = 8
) (
  input logic CLK_25,
  input logic Reset,
  rvc_asap_5pl_vga_timing_gen_if.master vga
);

  // state    | meaning
  // ST_IDLE  | stopped, counters held at 0, raw sync/DE terms inactive
  // ST_RUN   | counting, Enable high
  // ST_DRAIN | Enable dropped, counting on until the end of the current frame
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt_x;
  logic [CNT_W-1:0]    r_cnt_y;
  logic [FRM_W-1:0]    r_frm_cnt;
  logic [PIPE_DLY-1:0] r_hs_pipe;
  logic [PIPE_DLY-1:0] r_vs_pipe;
  logic [PIPE_DLY-1:0] r_de_pipe;

  logic w_active;
  logic w_eol;
  logic w_eof;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_de_raw;

  assign w_active = (r_state != ST_IDLE);
  assign w_eol    = (r_cnt_x == H_LAST);
  assign w_eof    = w_eol && (r_cnt_y == V_LAST);

  assign w_hs_raw = w_active && (r_cnt_x >= HS_BEG) && (r_cnt_x < HS_END);
  assign w_vs_raw = w_active && (r_cnt_y >= VS_BEG) && (r_cnt_y < VS_END);
  assign w_de_raw = w_active && (r_cnt_x < H_ACT) && (r_cnt_y < V_ACT);

  always_ff @(posedge CLK_25) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_cnt_x   <= '0;
      r_cnt_y   <= '0;
      r_frm_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE:  if (vga.Enable) r_state <= ST_RUN;
        ST_RUN:   if (!vga.Enable) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (vga.Enable)  r_state <= ST_RUN;
          else if (w_eof)  r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase

      if (w_active) begin
        if (w_eol) begin
          r_cnt_x <= '0;
          r_cnt_y <= w_eof ? '0 : r_cnt_y + 1'b1;
        end else begin
          r_cnt_x <= r_cnt_x + 1'b1;
        end
        if (w_eof) r_frm_cnt <= r_frm_cnt + 1'b1;
      end else begin
        r_cnt_x <= '0;
        r_cnt_y <= '0;
      end
    end
  end

  // Keeps shifting while idle so the last frame's tail leaves the pipe on its own.
  always_ff @(posedge CLK_25) begin
    if (Reset) begin
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
      r_de_pipe <= '0;
    end else begin
      r_hs_pipe[0] <= w_hs_raw;
      r_vs_pipe[0] <= w_vs_raw;
      r_de_pipe[0] <= w_de_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
        r_de_pipe[i] <= r_de_pipe[i-1];
      end
    end
  end

  assign vga.vga_h_sync    = r_hs_pipe[PIPE_DLY-1] ? H_SYNC_POL : ~H_SYNC_POL;
  assign vga.vga_v_sync    = r_vs_pipe[PIPE_DLY-1] ? V_SYNC_POL : ~V_SYNC_POL;
  assign vga.inDisplayArea = r_de_pipe[PIPE_DLY-1];

  // Event pulses line up with the undelayed counters, not with the pipelined outputs.
  assign vga.CounterX    = r_cnt_x;
  assign vga.CounterY    = r_cnt_y;
  assign vga.FrameStart  = w_active && (r_cnt_x == '0) && (r_cnt_y == '0);
  assign vga.LineStart   = w_active && (r_cnt_x == '0);
  assign vga.VBlankStart = w_active && (r_cnt_x == '0) && (r_cnt_y == V_ACT);
  assign vga.Running     = w_active;
  assign vga.FrameCount  = r_frm_cnt;

endmodule

// File: doc/rvc_asap_5pl_vga_timing_gen.md
Name: rvc_asap_5pl_vga_timing_gen

Overview:
- Parametrised VGA raster timing generator, successor to the fixed 640x480 sync generator.
- Sits between the 25 MHz pixel clock domain and the VGA RGB/sync pads.
- Generates the pixel counters, the H/V syncs with configurable polarity, and the display-enable signal, delayed by a configurable pipeline depth so that pixel fetch sees the counters early.
- Adds run/stop control with a graceful frame-end stop, frame/line/vblank event pulses and a frame counter.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of vga_h_sync (0 = active low)
V_SYNC_POL, 0, asserted level of vga_v_sync
PIPE_DLY, 1, register stages from counters to sync/display outputs; legal range 1..4
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
FRM_W, 8, FrameCount width

Ports:
CLK_25  in  1  pixel clock
Reset  in  1  synchronous, active-high reset
Enable  in  1  run request, level-sensitive
vga_h_sync  out  1  horizontal sync, delayed PIPE_DLY
vga_v_sync  out  1  vertical sync, delayed PIPE_DLY
inDisplayArea  out  1  RGB-valid window, delayed PIPE_DLY
CounterX  out  CNT_W  current pixel column, undelayed
CounterY  out  CNT_W  current line, undelayed
FrameStart  out  1  one-cycle pulse at (0,0) while running
LineStart  out  1  one-cycle pulse at X==0 while running
VBlankStart  out  1  one-cycle pulse at X==0, Y==V_ACTIVE
Running  out  1  state != IDLE
FrameCount  out  FRM_W  completed frames, wraps

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (synchronous, dominant over all other inputs):
  - state IDLE, CounterX = CounterY = 0, FrameCount = 0.
  - All pipeline stages cleared: syncs at inactive level (~POL), inDisplayArea 0.
  - Event pulses and Running are 0.
- FSM states IDLE, RUN, DRAIN.
  - IDLE: counters held at 0. Enable=1 moves to RUN on the next cycle. The first RUN cycle has counters (0,0) and FrameStart=1.
  - RUN: on Enable=0, move to DRAIN; counting continues unchanged.
  - DRAIN: on Enable=1, return to RUN mid-frame with no restart. At end of frame, move to IDLE with counters set to 0.
- Counting in RUN/DRAIN:
  - X increments every cycle. At X==H_TOTAL-1, X wraps to 0 and Y increments.
  - At Y==V_TOTAL-1 together with X==H_TOTAL-1 (end of frame), Y wraps to 0.
  - Counters never reach H_TOTAL or V_TOTAL.
- End of frame:
  - In RUN: FrameCount increments, modulo 2^FRM_W.
  - In DRAIN: FrameCount also increments, then the FSM goes to IDLE.
- Raw (pre-pipeline) terms, all forced inactive in IDLE:
  - hs_act = X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_act = Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - de = X < H_ACTIVE and Y < V_ACTIVE.
- Pipeline outputs:
  - The raw terms pass through PIPE_DLY registers.
  - vga_h_sync = hs_act_d ? H_SYNC_POL : ~H_SYNC_POL; vga_v_sync likewise with V_SYNC_POL.
  - The pipeline keeps shifting in IDLE, so the last frame's tail drains naturally.
- Event pulses:
  - FrameStart, LineStart and VBlankStart are combinational from the current counters and state, gated by state != IDLE. They align with CounterX/CounterY, not with the delayed outputs.
- Simultaneous events:
  - Enable falling on the end-of-frame cycle in RUN: go to DRAIN. The next frame is then fully drained.
  - Enable rising on the DRAIN end-of-frame cycle: go to RUN, no IDLE gap.
- Reset mid-line: counters return to 0 and outputs go inactive on the next edge, regardless of state.

Test Plan:
1. Reset with Enable=1, then release Reset -> 1 cycle in IDLE, then FrameStart=1 at (0,0). Default params: next FrameStart after exactly 420000 cycles; FrameCount=1 at that point.
2. Defaults, PIPE_DLY=1, running -> vga_h_sync low exactly while CounterX was 656..751 one cycle earlier (96 clocks). vga_v_sync low for 1600 clocks covering Y=490..491. inDisplayArea high 640 clocks per line for Y<480 only.
3. PIPE_DLY=3, H_SYNC_POL=1 -> vga_h_sync high, starting 3 cycles after CounterX==656. inDisplayArea falls 3 cycles after CounterX==640.
4. Deassert Enable at (100,200) -> Running stays 1 until the (799,524) cycle. Next cycle: IDLE, counters 0, syncs inactive after PIPE_DLY. FrameCount incremented once.
5. In DRAIN, reassert Enable at (5,300) -> counting continues to (6,300), no FrameStart until the natural frame wrap.
6. Assert Reset for 1 cycle at (400,100) in RUN -> next cycle counters (0,0), state IDLE, FrameCount 0, inDisplayArea 0, syncs inactive.
